// File: rtl/adc_pattern_gen_if.sv
// Sample-domain bundle between the pattern generator and its consumer: controls in, samples and markers out.
// The capture side and the bench drive through master; the generator sits on slave.
interface adc_pattern_gen_if #(
  parameter int DATA_W = 14,
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  logic                     enable_i;
  logic [2:0]               mode_i;
  logic [DATA_W-1:0]        step_i;
  logic [DATA_W-1:0]        const_i;
  logic [CNT_W-1:0]         pulse_period_i;
  logic [CNT_W-1:0]         pulse_width_i;
  logic [NUM_CH*DATA_W-1:0] data_o;
  logic                     valid_o;
  logic                     frame_o;

  modport master (
    output enable_i, mode_i, step_i, const_i, pulse_period_i, pulse_width_i,
    input  data_o, valid_o, frame_o
  );

  modport slave (
    input  enable_i, mode_i, step_i, const_i, pulse_period_i, pulse_width_i,
    output data_o, valid_o, frame_o
  );
endinterface

// File: rtl/adc_pattern_gen.sv
// Multi-channel ADC stand-in: ramp/const/toggle/PRBS-15/pulse pattern plus per-channel offset, all outputs registered (1 cycle).
// No backpressure: enable_i=0 freezes state and drops valid; a mode change costs one invalid bubble cycle.
module adc_pattern_gen #(
  parameter int DATA_W    = 14,
  parameter int NUM_CH    = 2,
  parameter int CH_OFFSET = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  adc_pattern_gen_if.slave   bus
);

  typedef enum logic [2:0] {
    MODE_RAMP   = 3'd0,
    MODE_CONST  = 3'd1,
    MODE_TOGGLE = 3'd2,
    MODE_PRBS   = 3'd3,
    MODE_PULSE  = 3'd4
  } mode_e;

  localparam logic [14:0] LFSR_SEED = 15'h7FFF;

  logic [2:0]               mode_q, mode_d;
  logic [DATA_W-1:0]        acc_q, acc_d;
  logic [14:0]              lfsr_q, lfsr_d;
  logic [CNT_W-1:0]         pcnt_q, pcnt_d;
  logic                     phase_q, phase_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     frame_q, frame_d;

  logic [DATA_W-1:0]        base;
  logic [CNT_W:0]           pcnt_inc;

  always_comb begin
    mode_d   = mode_q;
    acc_d    = acc_q;
    lfsr_d   = lfsr_q;
    pcnt_d   = pcnt_q;
    phase_d  = phase_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    frame_d  = frame_q;
    base     = '0;
    pcnt_inc = {1'b0, pcnt_q} + {{CNT_W{1'b0}}, 1'b1};

    if (bus.enable_i) begin
      if (bus.mode_i != mode_q) begin
        // Bubble cycle: restart the pattern, keep the last sample on the bus.
        mode_d  = bus.mode_i;
        acc_d   = '0;
        lfsr_d  = LFSR_SEED;
        pcnt_d  = '0;
        phase_d = 1'b0;
        frame_d = 1'b0;
      end else begin
        valid_d = 1'b1;
        frame_d = 1'b0;
        case (mode_q)
          MODE_RAMP: begin
            base  = acc_q;
            acc_d = acc_q + bus.step_i;
          end
          MODE_CONST: base = bus.const_i;
          MODE_TOGGLE: begin
            base    = phase_q ? ~bus.const_i : bus.const_i;
            phase_d = ~phase_q;
          end
          MODE_PRBS: begin
            base   = lfsr_q[DATA_W-1:0];
            lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
          end
          MODE_PULSE: begin
            base    = (pcnt_q < bus.pulse_width_i) ? bus.const_i : '0;
            frame_d = (pcnt_q == '0);
            // Period 0 or 1 always wraps, so every sample starts a frame.
            pcnt_d  = (pcnt_inc >= {1'b0, bus.pulse_period_i}) ? '0 : pcnt_inc[CNT_W-1:0];
          end
          default: base = '0;
        endcase
        for (int k = 0; k < NUM_CH; k++) begin
          data_d[k*DATA_W +: DATA_W] = base + DATA_W'(k * CH_OFFSET);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_q  <= MODE_RAMP;
      acc_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      pcnt_q  <= '0;
      phase_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      lfsr_q  <= lfsr_d;
      pcnt_q  <= pcnt_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Bench for adc_pattern_gen: sample-index model compared every cycle, plus hand-computed anchors.
module tb_adc_pattern_gen;
  localparam int DW   = 14;
  localparam int NCH  = 2;
  localparam int CHO  = 1;
  localparam int CW   = 16;
  localparam int MOD  = 1 << DW;
  localparam int MASK = MOD - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adc_pattern_gen_if #(.DATA_W(DW), .NUM_CH(NCH), .CNT_W(CW)) bus ();

  adc_pattern_gen #(.DATA_W(DW), .NUM_CH(NCH), .CH_OFFSET(CHO), .CNT_W(CW)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: pattern value as a function of the sample index since the last mode start.
  int prbs [32767];
  int m_mode, m_n, m_acc, m_valid, m_frame, m_b, m_pos;
  int m_data [NCH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_n = 0; m_acc = 0; m_valid = 0; m_frame = 0;
      for (int k = 0; k < NCH; k++) m_data[k] = 0;
    end else if (bus.enable_i) begin
      if (int'(bus.mode_i) != m_mode) begin
        m_mode = int'(bus.mode_i); m_n = 0; m_acc = 0; m_valid = 0; m_frame = 0;
      end else begin
        m_valid = 1; m_frame = 0;
        case (m_mode)
          0: begin m_b = m_acc; m_acc = (m_acc + int'(bus.step_i)) % MOD; end
          1: m_b = int'(bus.const_i);
          2: m_b = (m_n % 2 == 0) ? int'(bus.const_i) : (MASK ^ int'(bus.const_i));
          3: m_b = prbs[m_n % 32767] & MASK;
          4: begin
            m_pos   = (bus.pulse_period_i <= 1) ? 0 : m_n % int'(bus.pulse_period_i);
            m_b     = (m_pos < int'(bus.pulse_width_i)) ? int'(bus.const_i) : 0;
            m_frame = (m_pos == 0) ? 1 : 0;
          end
          default: m_b = 0;
        endcase
        m_n++;
        for (int k = 0; k < NCH; k++) m_data[k] = (m_b + k * CHO) % MOD;
      end
    end else begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("valid", 32'(bus.valid_o), m_valid);
      check("frame", 32'(bus.frame_o), m_frame);
      for (int k = 0; k < NCH; k++)
        check($sformatf("data_ch%0d", k), 32'(bus.data_o[k*DW +: DW]), m_data[k]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ch(input int k);
    return int'(bus.data_o[k*DW +: DW]);
  endfunction

  task automatic set_in(input bit en, input int mode, input int step, input int cval,
                        input int per, input int wid);
    bus.enable_i       = en;
    bus.mode_i         = 3'(mode);
    bus.step_i         = DW'(step);
    bus.const_i        = DW'(cval);
    bus.pulse_period_i = CW'(per);
    bus.pulse_width_i  = CW'(wid);
  endtask

  initial begin
    prbs[0] = 15'h7FFF;
    for (int i = 1; i < 32767; i++)
      prbs[i] = ((prbs[i-1] << 1) & 15'h7FFF) | (((prbs[i-1] >> 14) ^ (prbs[i-1] >> 13)) & 1);

    set_in(1'b0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    cmp_on = 1'b1;
    tick(); tick();
    check("rst_data", 32'(bus.data_o), 0);
    check("rst_valid", 32'(bus.valid_o), 0);
    check("rst_frame", 32'(bus.frame_o), 0);

    // Ramp step 3 through the 14-bit wrap.
    set_in(1'b1, 0, 3, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 5463; i++) begin
      tick();
      if (i == 0) begin
        check("ramp_first_ch0", ch(0), 0);
        check("ramp_first_ch1", ch(1), 1);
        check("ramp_first_valid", 32'(bus.valid_o), 1);
      end
      if (i == 1)    check("ramp_second_ch0", ch(0), 3);
      if (i == 5461) check("ramp_top_ch0", ch(0), 16383);
      if (i == 5462) begin
        check("ramp_wrap_ch0", ch(0), 2);
        check("ramp_wrap_ch1", ch(1), 3);
      end
    end

    // Enable 1,0,0,1 with step 1: hold then resume without skipping.
    bus.step_i = DW'(1);
    tick(); check("en1_ch0", ch(0), 5); check("en1_valid", 32'(bus.valid_o), 1);
    bus.enable_i = 1'b0;
    tick(); check("en0a_ch0", ch(0), 5); check("en0a_valid", 32'(bus.valid_o), 0);
    tick(); check("en0b_ch0", ch(0), 5); check("en0b_valid", 32'(bus.valid_o), 0);
    bus.enable_i = 1'b1;
    tick(); check("en1b_ch0", ch(0), 6); check("en1b_valid", 32'(bus.valid_o), 1);

    // Ramp -> toggle: one bubble then the alternating level.
    set_in(1'b1, 2, 1, 16'h0AAA, 0, 0);
    tick(); check("tog_bubble_valid", 32'(bus.valid_o), 0); check("tog_bubble_hold", ch(0), 6);
    tick(); check("tog0_ch0", ch(0), 16'h0AAA); check("tog0_ch1", ch(1), 16'h0AAB);
    tick(); check("tog1_ch0", ch(0), 16'h3555);
    tick(); check("tog2_ch0", ch(0), 16'h0AAA);

    // Pulse period 10 width 3.
    set_in(1'b1, 4, 0, 16'h1000, 10, 3);
    tick(); check("pulse_bubble_frame", 32'(bus.frame_o), 0);
    for (int i = 0; i < 25; i++) begin
      tick();
      if (i == 0)  begin check("pulse0_ch0", ch(0), 16'h1000); check("pulse0_frame", 32'(bus.frame_o), 1); end
      if (i == 2)  check("pulse2_ch0", ch(0), 16'h1000);
      if (i == 3)  begin check("pulse3_ch0", ch(0), 0); check("pulse3_frame", 32'(bus.frame_o), 0); end
      if (i == 9)  check("pulse9_ch1", ch(1), 1);
      if (i == 10) begin check("pulse10_frame", 32'(bus.frame_o), 1); check("pulse10_ch0", ch(0), 16'h1000); end
    end

    // Hop through constant, then pulse with period 1, width 0 then width 5.
    bus.mode_i = 3'd1;
    tick(); tick(); check("const_ch0", ch(0), 16'h1000);
    set_in(1'b1, 4, 0, 16'h1000, 1, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 2) begin
        check("p1w0_frame", 32'(bus.frame_o), 1);
        check("p1w0_ch0", ch(0), 0);
        check("p1w0_ch1", ch(1), 1);
      end
    end
    bus.pulse_width_i = CW'(5);
    for (int i = 0; i < 3; i++) tick();
    check("p1w5_ch0", ch(0), 16'h1000);
    check("p1w5_frame", 32'(bus.frame_o), 1);

    // Reserved mode.
    bus.mode_i = 3'd5;
    tick(); check("rsv_bubble_valid", 32'(bus.valid_o), 0);
    tick();
    check("rsv_valid", 32'(bus.valid_o), 1);
    check("rsv_frame", 32'(bus.frame_o), 0);
    check("rsv_ch1", ch(1), 1);

    // PRBS after a reset pulse.
    rst = 1'b1; #1 rst = 1'b0;
    set_in(1'b1, 3, 0, 0, 0, 0);
    tick(); check("prbs_bubble_valid", 32'(bus.valid_o), 0);
    tick(); check("prbs0_ch0", ch(0), 16'h3FFF);
    tick(); check("prbs1_ch0", ch(0), 16'h3FFE);
    tick(); check("prbs2_ch0", ch(0), 16'h3FFC); check("prbs2_ch1", ch(1), 16'h3FFD);
    for (int i = 0; i < 120; i++) tick();

    // Asynchronous reset mid-cycle, then ramp restarts with no bubble.
    set_in(1'b1, 0, 1, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    check("arst_data", 32'(bus.data_o), 0);
    check("arst_valid", 32'(bus.valid_o), 0);
    check("arst_frame", 32'(bus.frame_o), 0);
    #1 rst = 1'b0;
    tick(); check("post_rst_valid", 32'(bus.valid_o), 1); check("post_rst_ch0", ch(0), 0);
    tick(); check("post_rst_ch0_b", ch(0), 1);
    tick();

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
